// File: rtl/debug_host_controller.sv
// debug_host_controller: sequences SystemTest debug-port accesses and CPU runs from host commands.
module debug_host_controller #(
  parameter int unsigned RUN_TIMEOUT = 65535,
  parameter logic [8:0]  FETCH_STATE = 9'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_op_i,
  input  logic [15:0] cmd_addr_i,
  input  logic [15:0] cmd_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [15:0] rsp_data_o,
  output logic        rsp_ok_o,
  output logic        test_o,
  output logic        memoryoperation_o,
  output logic        registeroperation_o,
  output logic        memorywrite_o,
  output logic        registerwrite_o,
  output logic [15:0] memaddress_o,
  output logic [15:0] memwritedata_o,
  output logic [15:0] regwritedata_o,
  output logic [15:0] resetpc_o,
  output logic [3:0]  registeraddress_o,
  output logic        cpu_reset_o,
  input  logic [15:0] rd_i,
  input  logic [15:0] md_i,
  input  logic [8:0]  state_i
);
  typedef enum logic [2:0] {IDLE, ACC1, ACC2, CHECK, RUN_RST, RUN_GO, RUN_WAIT, RESP} state_e;
  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] addr_q, addr_d, data_q, data_d, cnt_q, cnt_d, cnt_n, sample;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic [31:0] cyc_q, cyc_d, cyc_n;
  logic        rsp_ok_q, rsp_ok_d, prev_fetch_q, fetch_evt, done, acc_d;
  logic        memop_q, regop_q, memwr_q, regwr_q, test_q, cpu_reset_q, cmd_ready_q, rsp_valid_q;
  logic [15:0] memaddr_q, memwdata_q, regwdata_q, resetpc_q, memaddr_d, memwdata_d, regwdata_d, resetpc_d;
  logic [3:0]  regaddr_q, regaddr_d;
  // op[0] selects the register file, op[1] clear means a write
  assign sample    = op_q[0] ? rd_i : md_i;
  assign fetch_evt = (state_i == FETCH_STATE) && !prev_fetch_q;
  assign cnt_n     = cnt_q + {15'd0, fetch_evt && (cnt_q != 16'hFFFF)};
  assign cyc_n     = cyc_q + 32'd1;
  assign done      = {1'b0, cnt_n} == ({1'b0, data_q} + 17'd1);
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    rsp_data_d = rsp_data_q;
    rsp_ok_d   = rsp_ok_q;
    case (state_q)
      IDLE: if (cmd_valid_i && cmd_ready_q) begin
        op_d    = cmd_op_i;
        addr_d  = cmd_addr_i;
        data_d  = cmd_data_i;
        state_d = cmd_op_i == 3'd4 ? RUN_RST : cmd_op_i > 3'd4 ? RESP : ACC1;
        if (cmd_op_i > 3'd4) begin
          rsp_data_d = '0;
          rsp_ok_d   = 1'b0;
        end
      end
      ACC1:    state_d = ACC2;
      ACC2:    state_d = CHECK;
      CHECK: begin
        rsp_data_d = sample;
        rsp_ok_d   = op_q[1] ? 1'b1 : (sample == data_q);
        state_d    = RESP;
      end
      RUN_RST: state_d = RUN_GO;
      RUN_GO: begin
        cnt_d   = '0;
        cyc_d   = '0;
        state_d = RUN_WAIT;
      end
      RUN_WAIT: begin
        cnt_d = cnt_n;
        cyc_d = cyc_n;
        if (done) begin
          state_d    = RESP;
          rsp_ok_d   = 1'b1;
          rsp_data_d = cnt_n - 16'd1;
        end else if (cyc_n == RUN_TIMEOUT) begin
          state_d    = RESP;
          rsp_ok_d   = 1'b0;
          rsp_data_d = cnt_n;
        end
      end
      RESP:    state_d = rsp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // port values are derived from the next state so every test-port output is a flop
  assign acc_d      = (state_d == ACC1) || (state_d == ACC2);
  assign memaddr_d  = (state_d == ACC1 && !op_d[0]) ? addr_d : memaddr_q;
  assign memwdata_d = (state_d == ACC1 && op_d[1:0] == 2'b00) ? data_d : memwdata_q;
  assign regaddr_d  = (state_d == ACC1 && op_d[0]) ? addr_d[3:0] : regaddr_q;
  assign regwdata_d = (state_d == ACC1 && op_d[1:0] == 2'b01) ? data_d : regwdata_q;
  assign resetpc_d  = (state_d == RUN_RST) ? addr_d : resetpc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      cyc_q        <= '0;
      rsp_data_q   <= '0;
      rsp_ok_q     <= 1'b0;
      prev_fetch_q <= 1'b0;
      memop_q      <= 1'b0;
      regop_q      <= 1'b0;
      memwr_q      <= 1'b0;
      regwr_q      <= 1'b0;
      test_q       <= 1'b0;
      cpu_reset_q  <= 1'b0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      memaddr_q    <= '0;
      memwdata_q   <= '0;
      regwdata_q   <= '0;
      resetpc_q    <= '0;
      regaddr_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      cyc_q        <= cyc_d;
      rsp_data_q   <= rsp_data_d;
      rsp_ok_q     <= rsp_ok_d;
      prev_fetch_q <= state_i == FETCH_STATE;
      memop_q      <= acc_d && !op_d[0];
      regop_q      <= acc_d && op_d[0];
      memwr_q      <= acc_d && op_d[1:0] == 2'b00;
      regwr_q      <= acc_d && op_d[1:0] == 2'b01;
      test_q       <= (state_d == RUN_GO) || (state_d == RUN_WAIT);
      cpu_reset_q  <= state_d == RUN_RST;
      cmd_ready_q  <= state_d == IDLE;
      rsp_valid_q  <= state_d == RESP;
      memaddr_q    <= memaddr_d;
      memwdata_q   <= memwdata_d;
      regwdata_q   <= regwdata_d;
      resetpc_q    <= resetpc_d;
      regaddr_q    <= regaddr_d;
    end
  end
  assign cmd_ready_o         = cmd_ready_q;
  assign rsp_valid_o         = rsp_valid_q;
  assign rsp_data_o          = rsp_data_q;
  assign rsp_ok_o            = rsp_ok_q;
  assign test_o              = test_q;
  assign memoryoperation_o   = memop_q;
  assign registeroperation_o = regop_q;
  assign memorywrite_o       = memwr_q;
  assign registerwrite_o     = regwr_q;
  assign memaddress_o        = memaddr_q;
  assign memwritedata_o      = memwdata_q;
  assign regwritedata_o      = regwdata_q;
  assign resetpc_o           = resetpc_q;
  assign registeraddress_o   = regaddr_q;
  assign cpu_reset_o         = cpu_reset_q;
endmodule
